// File: rtl/wb_reader_pkg.sv
// Shared types and constants for the Wishbone sample reader.
package wb_reader_pkg;

  // Reader state machine encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // The reader always fetches full 32-bit words.
  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/wb_sample_reader_if.sv
// Wishbone classic read bus plus the valid/ready sample stream.
// The master side is the reader; the slave side is the responder and sink.
interface wb_sample_reader_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i,
    output m_data_o, m_valid_o,
    input  m_ready_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i,
    input  m_data_o, m_valid_o,
    output m_ready_i
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Ack-wait counter: counts cycles spent waiting for ack; tc flags the
// last allowed wait cycle so the reader gives up exactly TIMEOUT cycles
// after stb first rose.
module wb_timeout_cnt #(
  parameter  int TIMEOUT = 255,
  localparam int W       = $clog2(TIMEOUT + 1)
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         clr,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         tc
);

  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Clear has priority over load, load over increment.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/wb_sample_reader.sv
// Wishbone classic initiator that reads a contiguous word range from the
// ADC sample memory and presents each word on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start; bus and stream quiet
// REQ   | cyc/stb asserted, waiting for ack or timeout
// OUT   | word held on the stream until the sink takes it
module wb_sample_reader
  import wb_reader_pkg::*;
#(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [31:0]       base_addr_i,
  input  logic [CNT_W-1:0]  word_cnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  wb_sample_reader_if.master bus
);

  state_t           state;
  logic [31:0]      addr;
  logic [CNT_W-1:0] rem;
  logic             cyc;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             tmo_tc;

  // Counter runs only while a request is outstanding and sits at zero
  // otherwise, so every REQ entry starts a fresh wait window.
  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .clr       (state != REQ),
    .en        (state == REQ),
    .ld        (1'b0),
    .ld_val    ('0),
    .tc        (tmo_tc)
  );

  // Main sequencer; abort overrides every state, ack beats timeout.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      cyc     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_i) begin
        state   <= IDLE;
        cyc     <= 1'b0;
        m_valid <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              err <= 1'b0;
              if (word_cnt_i != '0) begin
                addr  <= base_addr_i & ~32'd3;
                rem   <= word_cnt_i;
                busy  <= 1'b1;
                cyc   <= 1'b1;
                state <= REQ;
              end else begin
                done <= 1'b1;
              end
            end
          end
          REQ: begin
            if (bus.wbm_ack_i) begin
              m_data  <= bus.wbm_dat_i;
              m_valid <= 1'b1;
              cyc     <= 1'b0;
              state   <= OUT;
            end else if (tmo_tc) begin
              cyc   <= 1'b0;
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          OUT: begin
            if (bus.m_ready_i) begin
              m_valid <= 1'b0;
              rem     <= rem - CNT_W'(1);
              addr    <= addr + WORD_BYTES;
              if (rem == CNT_W'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                cyc   <= 1'b1;
                state <= REQ;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o        = busy;
  assign done_o        = done;
  assign err_o         = err;
  assign bus.wbm_cyc_o = cyc;
  assign bus.wbm_stb_o = cyc;
  assign bus.wbm_we_o  = 1'b0;
  assign bus.wbm_sel_o = WB_SEL_ALL;
  assign bus.wbm_adr_o = addr;
  assign bus.wbm_dat_o = '0;
  assign bus.m_data_o  = m_data;
  assign bus.m_valid_o = m_valid;

endmodule
